ram_loader: RTL and testbench
=============================

# ram_loader

Byte-stream program loader that sits directly upstream of the 8-word RAM block and drives its `data`/`load`/`address` inputs. It accepts bytes over a valid/ready handshake, packs each pair (high byte first) into a 16-bit word, and writes the words to consecutive RAM addresses from 0. It keeps a running checksum and signals completion. With verification compiled in, it reads the RAM back through its one-cycle synchronous read port and compares the result.

## Interface
Parameters:
- `ADDR_W`, 3, RAM address width.
- `WORDS`, 8, words per load. Legal range is 1..2^ADDR_W.

Ports (vectors are `[0:N-1]`, bit 0 = MSB):
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle pulse that begins a load. Ignored while `busy`.
- `byte_in`  in  8  stream byte.
- `byte_valid`  in  1  `byte_in` valid.
- `byte_ready`  out  1  loader can accept a byte.
- `ram_data`  out  16  word to the RAM `data` input.
- `ram_load`  out  1  RAM write enable.
- `ram_address`  out  ADDR_W  RAM address.
- `ram_out`  in  16  RAM registered read data.
- `busy`  out  1  load (or verify) in progress.
- `done`  out  1  load finished. Held until the next accepted `start`.
- `checksum`  out  16  modulo-2^16 sum of the words written.
- `verify_err`  out  1  readback mismatch (see Configuration).

## Operation
- A byte transfers on a rising edge when `byte_valid && byte_ready`.
- States: IDLE, RECV_HI, RECV_LO, WRITE, VERIFY (present only with macro), DONE.
- **IDLE / DONE**
  - On `start`: go to RECV_HI, clear `addr`, `checksum`, `verify_err` and `done`; `busy` goes to 1.
- **RECV_HI**
  - `byte_ready`=1.
  - On transfer: latch the byte into `ram_data[0:7]` and go to RECV_LO.
- **RECV_LO**
  - `byte_ready`=1.
  - On transfer: latch the byte into `ram_data[8:15]` and go to WRITE.
- **WRITE** (exactly one cycle)
  - `ram_load`=1 with `ram_address`=`addr`; `byte_ready`=0.
  - `checksum` <= `checksum` + word, wrapping at 16 bits.
  - If `addr`==WORDS-1: go to VERIFY (macro) or DONE.
  - Otherwise: `addr` increments and the next state is RECV_HI.
- **In DONE:**
  - `done`=1 and `busy`=0.
  - `ram_address`, `ram_data` and `checksum` hold their final values.
- `byte_valid` outside RECV_HI/RECV_LO is ignored; the byte is not consumed.
- `start` while busy has no effect.
- `ram_load` is 1 only in WRITE and never during VERIFY.
- Reset (asserted at any time, including mid-load):
  - All outputs go to 0 and the state to IDLE.
  - RAM words already written stay as written. No partial word is ever written.

## Timing
- Minimum time per word is 3 cycles: HI transfer, LO transfer, WRITE.
- A full load takes at least 3*WORDS cycles from the first byte transfer to entering DONE.
- `done` rises on the edge after the last WRITE cycle (no macro), or the edge after the last VERIFY compare (macro).
- Back-to-back: the first byte of the next word can transfer in the cycle immediately after WRITE.
- `byte_ready` is a registered function of state only. It does not depend combinationally on `byte_valid`.
- VERIFY:
  - Addresses 0..WORDS-1 are driven on consecutive cycles.
  - Each `ram_out` is sampled one cycle after its address (RAM read latency 1).
  - VERIFY therefore lasts WORDS+1 cycles.

## Configuration
- Macro `RAM_LOADER_VERIFY_EN`.
- **Defined:**
  - After the last WRITE, run VERIFY and accumulate a modulo-2^16 readback sum.
  - At the end, set `verify_err`=1 if the readback sum is not equal to `checksum`, then go to DONE.
- **Undefined:**
  - The VERIFY state and the readback accumulator are absent.
  - WRITE goes straight to DONE.
  - `verify_err` is tied to 0 and `ram_out` is unused.

## Test plan
- Reset mid-RECV_LO after one full word was written → all outputs 0, state IDLE, `byte_ready`=0. Word 0 in RAM is unchanged and word 1 is never written.
- `start`, then bytes 0x12,0x34,0x56,0x78,…, with `byte_valid` held high → writes 0x1234 at address 0 and 0x5678 at address 1, each with `ram_load` high for exactly 1 cycle. With WORDS=8: `done`=1 after exactly 24 transfer/write cycles.
- Feed 16 bytes of 0xFF → `checksum`=0xFFF8, showing wrap-around.
- Random gaps in `byte_valid`, plus a `start` pulse mid-load → no bytes are lost or duplicated, and the `start` is ignored. The final RAM contents and `checksum` match the model.
- With `RAM_LOADER_VERIFY_EN`, connect a RAM model and load 8 words → `verify_err`=0, and `done` rises 9 cycles after the last WRITE. Forcing one RAM word corrupt before VERIFY → `verify_err`=1.
- WORDS=1 → exactly one WRITE at address 0, then DONE; `byte_ready` stays 0 until the next `start`.

Source files
------------

// File: rtl/ram_loader_if.sv
// ram_loader_if: byte-stream handshake plus RAM write/readback bus of the program loader.
// master = loader side, slave = stream source / RAM side.
interface ram_loader_if #(
  parameter int ADDR_W = 3
);
  logic              start;
  logic [0:7]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic [0:15]       ram_data;
  logic              ram_load;
  logic [0:ADDR_W-1] ram_address;
  logic [0:15]       ram_out;
  logic              busy;
  logic              done;
  logic [0:15]       checksum;
  logic              verify_err;
  modport master (
    input  start, byte_in, byte_valid, ram_out,
    output byte_ready, ram_data, ram_load, ram_address, busy, done, checksum, verify_err
  );
  modport slave (
    output start, byte_in, byte_valid, ram_out,
    input  byte_ready, ram_data, ram_load, ram_address, busy, done, checksum, verify_err
  );
endinterface

// File: rtl/ram_loader.sv
// ram_loader: packs byte pairs (high first) into words written to RAM from address 0, with running checksum.
// Optional RAM_LOADER_VERIFY_EN reads the RAM back and flags a readback-sum mismatch.
module ram_loader #(
  parameter int ADDR_W = 3,
  parameter int WORDS  = 8
) (
  input logic          clk,
  input logic          rst_n,
  ram_loader_if.master lb
);
`ifdef RAM_LOADER_VERIFY_EN
  typedef enum logic [2:0] {IDLE, RECV_HI, RECV_LO, WRITE, VERIFY, DONE} state_t;
  localparam int CNT_W = ADDR_W + 1;
  logic [CNT_W-1:0] vcnt_q, vcnt_d;
  logic [15:0]      rsum_q, rsum_d;
  logic             verr_q, verr_d;
`else
  typedef enum logic [2:0] {IDLE, RECV_HI, RECV_LO, WRITE, DONE} state_t;
`endif
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       data_q, data_d;
  logic [15:0]       sum_q, sum_d;
  logic              done_q, done_d;
  logic              last;
  assign last = addr_q == ADDR_W'(WORDS - 1);
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    sum_d   = sum_q;
    done_d  = done_q;
`ifdef RAM_LOADER_VERIFY_EN
    vcnt_d  = vcnt_q;
    rsum_d  = rsum_q;
    verr_d  = verr_q;
`endif
    case (state_q)
      IDLE, DONE: if (lb.start) begin
        state_d = RECV_HI;
        addr_d  = '0;
        sum_d   = '0;
        done_d  = 1'b0;
`ifdef RAM_LOADER_VERIFY_EN
        verr_d  = 1'b0;
`endif
      end
      RECV_HI: if (lb.byte_valid) begin
        data_d[15:8] = lb.byte_in;
        state_d      = RECV_LO;
      end
      RECV_LO: if (lb.byte_valid) begin
        data_d[7:0] = lb.byte_in;
        state_d     = WRITE;
      end
      WRITE: begin
        sum_d = sum_q + data_q;
        if (last) begin
`ifdef RAM_LOADER_VERIFY_EN
          state_d = VERIFY;
          addr_d  = '0;
          vcnt_d  = '0;
          rsum_d  = '0;
`else
          state_d = DONE;
          done_d  = 1'b1;
`endif
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = RECV_HI;
        end
      end
`ifdef RAM_LOADER_VERIFY_EN
      // address k is on the bus in cycle k; its data returns in cycle k+1
      VERIFY: begin
        vcnt_d = vcnt_q + 1'b1;
        addr_d = last ? addr_q : addr_q + 1'b1;
        rsum_d = vcnt_q != '0 ? rsum_q + lb.ram_out : rsum_q;
        if (vcnt_q == CNT_W'(WORDS)) begin
          verr_d  = rsum_d != sum_q;
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      sum_q   <= '0;
      done_q  <= 1'b0;
`ifdef RAM_LOADER_VERIFY_EN
      vcnt_q  <= '0;
      rsum_q  <= '0;
      verr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      sum_q   <= sum_d;
      done_q  <= done_d;
`ifdef RAM_LOADER_VERIFY_EN
      vcnt_q  <= vcnt_d;
      rsum_q  <= rsum_d;
      verr_q  <= verr_d;
`endif
    end
  end
  assign lb.byte_ready  = state_q == RECV_HI || state_q == RECV_LO;
  assign lb.busy        = state_q != IDLE && state_q != DONE;
  assign lb.ram_load    = state_q == WRITE;
  assign lb.ram_address = addr_q;
  assign lb.ram_data    = data_q;
  assign lb.checksum    = sum_q;
  assign lb.done        = done_q;
`ifdef RAM_LOADER_VERIFY_EN
  assign lb.verify_err  = verr_q;
`else
  assign lb.verify_err  = 1'b0;
`endif
endmodule

// File: tb/tb_ram_loader.sv
// tb_ram_loader: random byte streams against a word-list model, with RAM models for 8-word and 1-word loaders.
module tb_ram_loader;
`ifdef RAM_LOADER_VERIFY_EN
  localparam bit VEN = 1'b1;
`else
  localparam bit VEN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  ram_loader_if #(.ADDR_W(3)) b8();
  ram_loader_if #(.ADDR_W(3)) b1();
  ram_loader #(.ADDR_W(3), .WORDS(8)) dut8 (.clk(clk), .rst_n(rst_n), .lb(b8));
  ram_loader #(.ADDR_W(3), .WORDS(1)) dut1 (.clk(clk), .rst_n(rst_n), .lb(b1));
  logic [15:0] mem [8];
  int          wr_cnt [8] = '{default: 0};
  logic [15:0] mem1;
  int          wr1 = 0;
  logic [2:0]  wr1_addr;
  bit          corrupt = 1'b0;
  int          errors = 0;
  int          checks = 0;
  always @(posedge clk) begin
    if (b8.ram_load) begin
      mem[b8.ram_address]    <= b8.ram_data;
      wr_cnt[b8.ram_address] <= wr_cnt[b8.ram_address] + 1;
    end
    b8.ram_out <= mem[b8.ram_address] ^ {15'd0, corrupt && b8.ram_address == 3'd3};
    if (b1.ram_load) begin
      mem1     <= b1.ram_data;
      wr1      <= wr1 + 1;
      wr1_addr <= b1.ram_address;
    end
    b1.ram_out <= mem1;
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic load8(input logic [7:0] q[$], input int gap, input bit poke, input string tag);
    int i = 0;
    int t = 0;
    int base [8];
    bit v;
    logic [15:0] w;
    logic [15:0] sum = '0;
    base = wr_cnt;
    b8.start = 1'b1;
    @(negedge clk);
    b8.start = 1'b0;
    while (!b8.done && t < 2000) begin
      v = i < q.size() && $urandom_range(99) >= gap;
      b8.byte_valid = v;
      b8.byte_in = v ? q[i] : 8'($urandom);
      b8.start = poke && t == 10;
      if (v && b8.byte_ready) i++;
      @(negedge clk);
      t++;
    end
    b8.byte_valid = 1'b0;
    b8.start = 1'b0;
    chk({tag, "_done"}, b8.done, 1);
    chk({tag, "_bytes"}, i, 16);
    for (int k = 0; k < 8; k++) begin
      w = {q[2*k], q[2*k+1]};
      sum += w;
      chk($sformatf("%s_mem%0d", tag, k), mem[k], w);
      chk($sformatf("%s_wr%0d", tag, k), wr_cnt[k] - base[k], 1);
    end
    chk({tag, "_sum"}, b8.checksum, sum);
    chk({tag, "_busy"}, {b8.busy, b8.byte_ready, b8.ram_load}, 0);
    chk({tag, "_addr"}, b8.ram_address, 7);
    chk({tag, "_data"}, b8.ram_data, {q[14], q[15]});
    chk({tag, "_verr"}, b8.verify_err, VEN && corrupt);
    if (gap == 0) chk({tag, "_cycles"}, t, VEN ? 33 : 24);
  endtask
  initial begin
    logic [7:0] q[$];
    logic [15:0] prev1;
    int base1;
    int n;
    int t;
    b8.start = 1'b0; b8.byte_valid = 1'b0; b8.byte_in = '0;
    b1.start = 1'b0; b1.byte_valid = 1'b0; b1.byte_in = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ctl", {b8.byte_ready, b8.busy, b8.done, b8.ram_load, b8.verify_err}, 0);
    chk("rst_bus", {b8.ram_data, b8.checksum, 5'(b8.ram_address)}, 0);
    q = {};
    for (int k = 0; k < 16; k++) q.push_back(8'h12 + 8'(k * 8'h22));
    load8(q, 0, 1'b0, "seq");
    chk("seq_w0", mem[0], 16'h1234);
    chk("seq_w1", mem[1], 16'h5678);
    q = {};
    for (int k = 0; k < 16; k++) q.push_back(8'hFF);
    load8(q, 0, 1'b0, "ff");
    chk("ff_wrap", b8.checksum, 16'hFFF8);
    for (int r = 0; r < 3; r++) begin
      q = {};
      for (int k = 0; k < 16; k++) q.push_back(8'($urandom));
      load8(q, 40, 1'b1, $sformatf("rnd%0d", r));
    end
`ifdef RAM_LOADER_VERIFY_EN
    corrupt = 1'b1;
    q = {};
    for (int k = 0; k < 16; k++) q.push_back(8'($urandom));
    load8(q, 0, 1'b0, "corrupt");
    corrupt = 1'b0;
`endif
    q = {8'hA1, 8'hB2, 8'hC3, 8'hD4};
    prev1 = mem[1];
    base1 = wr_cnt[1];
    b8.start = 1'b1;
    @(negedge clk);
    b8.start = 1'b0;
    n = 0;
    t = 0;
    while (n < 3 && t < 50) begin
      b8.byte_valid = 1'b1;
      b8.byte_in = q[n];
      if (b8.byte_ready) n++;
      @(negedge clk);
      t++;
    end
    b8.byte_valid = 1'b0;
    chk("mid_in_lo", {b8.byte_ready, b8.busy}, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ctl", {b8.byte_ready, b8.busy, b8.done, b8.ram_load, b8.verify_err}, 0);
    chk("mid_rst_bus", {b8.ram_data, b8.checksum, 5'(b8.ram_address)}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    b8.byte_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_idle_ready", {b8.byte_ready, b8.busy}, 0);
    b8.byte_valid = 1'b0;
    chk("mid_w0", mem[0], 16'hA1B2);
    chk("mid_w1_cnt", wr_cnt[1] - base1, 0);
    chk("mid_w1_val", mem[1], prev1);
    b1.start = 1'b1;
    @(negedge clk);
    b1.start = 1'b0;
    b1.byte_valid = 1'b1;
    n = 0;
    t = 0;
    while (!b1.done && t < 50) begin
      b1.byte_in = n == 0 ? 8'hC0 : 8'hDE;
      if (b1.byte_ready) n++;
      @(negedge clk);
      t++;
    end
    chk("w1_done", b1.done, 1);
    chk("w1_cycles", t, VEN ? 5 : 3);
    chk("w1_writes", wr1, 1);
    chk("w1_addr", wr1_addr, 0);
    chk("w1_mem", mem1, 16'hC0DE);
    chk("w1_sum", b1.checksum, 16'hC0DE);
    chk("w1_verr", b1.verify_err, 0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("w1_hold_ready%0d", k), b1.byte_ready, 0);
      @(negedge clk);
    end
    chk("w1_no_extra", wr1, 1);
    b1.start = 1'b1;
    @(negedge clk);
    b1.start = 1'b0;
    b1.byte_valid = 1'b0;
    chk("w1_restart", {b1.byte_ready, b1.busy, b1.done}, 3'b110);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
